// File: rtl/sprite_read_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sprite_read_arbiter                                         |
// | Purpose  : Shares the single registered read port of the sprite/area   |
// |            RAM among N_REQ layer requesters, one read per clock.       |
// |            Round-robin fairness, burst locking for row fetches and     |
// |            tagged return data so each layer can claim its pixel.       |
// | Ports    : Clk, Reset_n      - clock, synchronous active-low reset     |
// |            frame_start       - per-frame resynchronisation pulse       |
// |            req, req_addr     - per-layer request level and address     |
// |            gnt               - one-hot grant (combinational)           |
// |            ram_read_address  - RAM address for the granted requester   |
// |            ram_data_Out      - RAM data, one cycle after the address   |
// |            rd_valid/rd_id/rd_data - tagged return data                 |
// |            busy              - a burst owner currently holds the port  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module sprite_read_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 8,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_start,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       ram_read_address,
  input  logic [DATA_W-1:0]       ram_data_Out,
  output logic                    rd_valid,
  output logic [ID_W-1:0]         rd_id,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [7:0] c_burst_max = 8'(BURST_LEN);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [7:0]        r_burst_cnt;
  logic              r_rd_valid;
  logic [ID_W-1:0]   r_rd_id;

  logic [ID_W-1:0]   w_search_ptr;
  logic [ID_W-1:0]   w_winner;
  logic              w_any;
  logic              w_hold;
  logic              w_grant;
  logic [ID_W-1:0]   w_grant_id;

  // Modulo-N_REQ increment that also works for non-power-of-two N_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // A frame_start cycle arbitrates as if the pointer were already reset.
  assign w_search_ptr = frame_start ? '0 : r_rr_ptr;

  // Round-robin search: iterate from the far end so the requester closest
  // to the pointer is the last (and therefore winning) assignment.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(w_search_ptr, k)]) begin
        w_any    = 1'b1;
        w_winner = wrap_add(w_search_ptr, k);
      end
    end
  end

  // The burst owner keeps the port while it still requests and has budget;
  // otherwise the cycle re-arbitrates immediately, leaving no bubble.
  assign w_hold = (r_state == S_BURST) && !frame_start &&
                  req[r_owner] && (r_burst_cnt < c_burst_max);

  assign w_grant    = Reset_n && (w_hold || w_any);
  assign w_grant_id = w_hold ? r_owner : w_winner;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  // With no request at all, the state (including a pending burst) is kept.
  always_comb begin
    w_state_nxt = r_state;
    if (frame_start)  w_state_nxt = S_IDLE;
    else if (w_hold)  w_state_nxt = S_BURST;
    else if (w_any)   w_state_nxt = (BURST_LEN > 1) ? S_BURST : S_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    gnt              = '0;
    ram_read_address = '0;
    if (w_grant) begin
      gnt[w_grant_id]  = 1'b1;
      ram_read_address = req_addr[int'(w_grant_id)*ADDR_W +: ADDR_W];
    end
  end

  assign busy = (r_state == S_BURST);

  // Arbitration bookkeeping and return-path tagging.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_id     <= '0;
    end else begin
      r_rd_valid <= w_grant;
      if (w_grant) r_rd_id <= w_grant_id;

      if (frame_start) begin
        r_rr_ptr    <= '0;
        r_burst_cnt <= '0;
      end else if (w_hold) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end else if (w_any) begin
        r_owner     <= w_winner;
        r_burst_cnt <= 8'd1;
        r_rr_ptr    <= wrap_add(w_winner, 1);
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_id    = r_rd_id;
  assign rd_data  = ram_data_Out;

endmodule
`default_nettype wire

// File: tb/tb_sprite_read_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sprite_read_arbiter                                      |
// | Purpose  : Directed self-checking bench for sprite_read_arbiter with    |
// |            a BURST_LEN=4 instance and a BURST_LEN=1 instance, each      |
// |            fed by a registered RAM model returning data = addr[3:0].    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_sprite_read_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 4;
  localparam int ID_W   = 2;

  typedef struct packed {
    logic             v;
    logic [ID_W-1:0]  id;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic                    frame_start;
  logic [N_REQ-1:0]        req;
  logic [ADDR_W-1:0]       a0, a1, a2, a3;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  assign req_addr = {a3, a2, a1, a0};

  // BURST_LEN = 4 instance
  logic [N_REQ-1:0]  gnt_4;
  logic [ADDR_W-1:0] addr_4;
  logic [DATA_W-1:0] ram_4;
  logic              valid_4, busy_4;
  logic [ID_W-1:0]   id_4;
  logic [DATA_W-1:0] data_4;

  // BURST_LEN = 1 instance
  logic [N_REQ-1:0]  gnt_1;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] ram_1;
  logic              valid_1, busy_1;
  logic [ID_W-1:0]   id_1;
  logic [DATA_W-1:0] data_1;

  sprite_read_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(4)) u_dut_b4 (
    .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .req(req), .req_addr(req_addr),
    .gnt(gnt_4), .ram_read_address(addr_4), .ram_data_Out(ram_4),
    .rd_valid(valid_4), .rd_id(id_4), .rd_data(data_4), .busy(busy_4)
  );

  sprite_read_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(1)) u_dut_b1 (
    .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .req(req), .req_addr(req_addr),
    .gnt(gnt_1), .ram_read_address(addr_1), .ram_data_Out(ram_1),
    .rd_valid(valid_1), .rd_id(id_1), .rd_data(data_1), .busy(busy_1)
  );

  // Registered-read RAM models: data = address low nibble, one cycle later.
  always_ff @(posedge clk) begin
    ram_4 <= addr_4[DATA_W-1:0];
    ram_1 <= addr_1[DATA_W-1:0];
  end

  // Select which instance the checks observe.
  logic              sel;
  logic [N_REQ-1:0]  obs_gnt;
  logic [ADDR_W-1:0] obs_addr;
  logic              obs_valid, obs_busy;
  logic [ID_W-1:0]   obs_id;
  logic [DATA_W-1:0] obs_data;

  always_comb begin
    obs_gnt   = sel ? gnt_1   : gnt_4;
    obs_addr  = sel ? addr_1  : addr_4;
    obs_valid = sel ? valid_1 : valid_4;
    obs_busy  = sel ? busy_1  : busy_4;
    obs_id    = sel ? id_1    : id_4;
    obs_data  = sel ? data_1  : data_4;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  function automatic logic [ID_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) if (oh[i]) r = ID_W'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: inputs were set at posedge+1; check the combinational
  // grant, queue the expected return, then check the return after the edge.
  // eb < 0 skips the busy check.
  task automatic step(input logic [N_REQ-1:0] eg, input logic [ADDR_W-1:0] ea, input int eb);
    exp_t e;
    #2;
    check("gnt", 32'(obs_gnt), 32'(eg));
    check("ram_read_address", 32'(obs_addr), 32'(ea));
    if (eb >= 0) check("busy", 32'(obs_busy), 32'(eb));
    e.v  = |eg;
    e.id = onehot_idx(eg);
    e.d  = ea[DATA_W-1:0];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("rd_valid", 32'(obs_valid), 32'(e.v));
    if (e.v) begin
      check("rd_id", 32'(obs_id), 32'(e.id));
      check("rd_data", 32'(obs_data), 32'(e.d));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step('0, '0, -1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    req         = '0;
    sel         = 1'b0;
    a0 = 18'h100; a1 = 18'h02A; a2 = 18'h200; a3 = 18'h300;
    @(posedge clk);
    #1;

    // Reset held with all requests active: no grants, no returns.
    req = 4'b1111;
    repeat (3) step(4'b0000, '0, 0);
    check("rd_id_reset", 32'(obs_id), 32'd0);
    rst_n = 1'b1;
    step(4'b0001, 18'h100, 0);
    step(4'b0001, 18'h100, 1);

    // Reset mid-burst: pointer returns to 0, first grant goes to req0 again.
    rst_n = 1'b0;
    step(4'b0000, '0, 1);
    rst_n = 1'b1;
    step(4'b0001, 18'h100, 0);

    // BURST_LEN = 1: pure rotation.
    do_reset();
    sel = 1'b1;
    req = 4'b1111;
    step(4'b0001, 18'h100, 0);
    step(4'b0010, 18'h02A, 0);
    step(4'b0100, 18'h200, 0);
    step(4'b1000, 18'h300, 0);
    step(4'b0001, 18'h100, 0);

    // BURST_LEN = 4: owner 0 for four incrementing addresses, then owner 1.
    sel = 1'b0;
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      a0 = 18'h100 + 18'(k);
      step(4'b0001, 18'h100 + 18'(k), (k == 0) ? 0 : 1);
    end
    for (int k = 0; k < 4; k++) step(4'b0010, 18'h02A, 1);
    step(4'b0001, 18'h103, 1);
    a0 = 18'h100;

    // Owner 2 drops after two grants: requester 3 takes over with no bubble.
    do_reset();
    req = 4'b1100;
    step(4'b0100, 18'h200, 0);
    step(4'b0100, 18'h200, 1);
    req = 4'b1000;
    step(4'b1000, 18'h300, 1);
    step(4'b1000, 18'h300, 1);

    // frame_start during owner 3's burst: arbitration restarts at requester 0.
    req         = 4'b1001;
    frame_start = 1'b1;
    step(4'b0001, 18'h100, 1);
    frame_start = 1'b0;
    step(4'b0001, 18'h100, -1);

    // No requests: no grant, address driven to zero.
    req = 4'b0000;
    step(4'b0000, '0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
